// File: rtl/fetch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_ctrl_if
//  Description : Hazard-unit, cache-hit and redirect-target bundle seen by the
//                fetch next-PC controller, plus the controller's PC outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_redirect_ctrl_if;
  logic        StallD;
  logic        Ihit;
  logic        Dhit;
  logic        JumpReg;
  logic        MistakeD;
  logic        BranchPrd;
  logic        Jump;
  logic [31:0] PCReg;
  logic [31:0] PCBranchD;
  logic [31:0] PCBranchF;
  logic [31:0] PCJump;
  logic [31:0] PCPlus4F;
  logic [31:0] NextPC;
  logic [2:0]  PCSel;
  logic        StallF;
  logic        FlushD;
  logic        RedirPend;

  // Pipeline side: supplies hazards, hits and targets, consumes next PC.
  modport master (
    output StallD, Ihit, Dhit, JumpReg, MistakeD, BranchPrd, Jump,
    output PCReg, PCBranchD, PCBranchF, PCJump, PCPlus4F,
    input  NextPC, PCSel, StallF, FlushD, RedirPend
  );

  // Controller side.
  modport slave (
    input  StallD, Ihit, Dhit, JumpReg, MistakeD, BranchPrd, Jump,
    input  PCReg, PCBranchD, PCBranchF, PCJump, PCPlus4F,
    output NextPC, PCSel, StallF, FlushD, RedirPend
  );
endinterface
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_ctrl
//  Description : Next-PC arbitration for the fetch stage. Picks among
//                JumpReg > MistakeD > BranchPrd > Jump > PCPlus4F, and holds a
//                decode redirect that arrives during a cache miss so it can be
//                replayed on the first cycle fetch advances.
//  Options     : FETCH_REDIR_PERF_EN adds RedirCnt / MissCycCnt counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_REDIR_PERF_EN
  ,
  parameter int          CNT_W    = 32
`endif
) (
  input  wire logic             clk,
  input  wire logic             reset,
  fetch_redirect_ctrl_if.slave  bus
`ifdef FETCH_REDIR_PERF_EN
  ,
  output logic [CNT_W-1:0]      RedirCnt,
  output logic [CNT_W-1:0]      MissCycCnt
`endif
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    MISS = 1'b1
  } state_t;

  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_JUMP   = 3'd1;
  localparam logic [2:0] SEL_BPRD   = 3'd2;
  localparam logic [2:0] SEL_MIST   = 3'd3;
  localparam logic [2:0] SEL_JREG   = 3'd4;
  localparam logic [2:0] SEL_REPLAY = 3'd5;

  state_t      state;
  state_t      state_nxt;
  logic        pvalid;
  logic [31:0] ptarget;

  logic        go;
  logic        jr_q;
  logic        md_q;
  logic [31:0] pc_raw;
  logic [2:0]  sel;
  logic        flush;
  logic        cap_en;
  logic [31:0] cap_target;
  logic        release_p;

  // Decode redirects only count when decode is not stalled; fetch advances on Go.
  assign go   = bus.Ihit & bus.Dhit & ~bus.StallD;
  assign jr_q = bus.JumpReg  & ~bus.StallD;
  assign md_q = bus.MistakeD & ~bus.StallD;

  // Next-state and next-PC selection; redirect takes effect in the same cycle.
  always_comb begin
    state_nxt  = state;
    pc_raw     = bus.PCPlus4F;
    sel        = SEL_SEQ;
    flush      = 1'b0;
    cap_en     = 1'b0;
    cap_target = bus.PCReg;
    release_p  = 1'b0;
    case (state)
      RUN: begin
        if (go) begin
          if (jr_q) begin
            pc_raw = bus.PCReg;
            sel    = SEL_JREG;
            flush  = 1'b1;
          end else if (md_q) begin
            pc_raw = bus.PCBranchD;
            sel    = SEL_MIST;
            flush  = 1'b1;
          end else if (bus.BranchPrd) begin
            pc_raw = bus.PCBranchF;
            sel    = SEL_BPRD;
          end else if (bus.Jump) begin
            pc_raw = bus.PCJump;
            sel    = SEL_JUMP;
          end
        end else if (jr_q || md_q) begin
          // Fetch is frozen: remember the redirect and squash the decode slot now.
          cap_en     = 1'b1;
          cap_target = jr_q ? bus.PCReg : bus.PCBranchD;
          flush      = 1'b1;
          state_nxt  = MISS;
        end
      end
      MISS: begin
        // Younger redirects and fetch-stage predictions are ignored until replay.
        if (go) begin
          pc_raw    = ptarget;
          sel       = SEL_REPLAY;
          flush     = 1'b1;
          release_p = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Reset overrides every output; the low two PC bits are always cleared.
  assign bus.NextPC    = (reset ? pc_raw : RESET_PC) & ~32'h3;
  assign bus.PCSel     = reset ? sel : SEL_SEQ;
  assign bus.StallF    = ~go | ~reset;
  assign bus.FlushD    = flush | ~reset;
  assign bus.RedirPend = pvalid;

  // State and pending-redirect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      pvalid  <= 1'b0;
      ptarget <= 32'h0;
    end else begin
      state <= state_nxt;
      if (cap_en) begin
        pvalid  <= 1'b1;
        ptarget <= cap_target;
      end else if (release_p) begin
        pvalid  <= 1'b0;
      end
    end
  end

`ifdef FETCH_REDIR_PERF_EN
  // Event counters: taken non-sequential redirects and I-cache miss cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RedirCnt   <= '0;
      MissCycCnt <= '0;
    end else begin
      if (go && (sel != SEL_SEQ)) begin
        RedirCnt <= RedirCnt + CNT_W'(1);
      end
      if (!bus.Ihit) begin
        MissCycCnt <= MissCycCnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_redirect_ctrl
//  Description : Directed self-checking bench for fetch_redirect_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_redirect_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fetch_redirect_ctrl_if bus ();

`ifdef FETCH_REDIR_PERF_EN
  logic [3:0] RedirCnt;
  logic [3:0] MissCycCnt;
  fetch_redirect_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .RedirCnt   (RedirCnt),
    .MissCycCnt (MissCycCnt)
  );
`else
  fetch_redirect_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`endif

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.StallD    = 1'b0;
    bus.Ihit      = 1'b1;
    bus.Dhit      = 1'b1;
    bus.JumpReg   = 1'b0;
    bus.MistakeD  = 1'b0;
    bus.BranchPrd = 1'b0;
    bus.Jump      = 1'b0;
    bus.PCReg     = 32'h0;
    bus.PCBranchD = 32'h0;
    bus.PCBranchF = 32'h0;
    bus.PCJump    = 32'h0;
    bus.PCPlus4F  = 32'h1004;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [2:0] s,
                         input logic stf, input logic fl);
    chk({tag, ".NextPC"}, bus.NextPC, pc);
    chk({tag, ".PCSel"},  {29'h0, bus.PCSel}, {29'h0, s});
    chk({tag, ".StallF"}, {31'h0, bus.StallF}, {31'h0, stf});
    chk({tag, ".FlushD"}, {31'h0, bus.FlushD}, {31'h0, fl});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    idle();
    #1;
    chk_out("reset", 32'h0, 3'd0, 1'b1, 1'b1);
    chk("reset.RedirPend", {31'h0, bus.RedirPend}, 32'h0);

    // Release reset, sequential fetch.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 chk_out("seq", 32'h1004, 3'd0, 1'b0, 1'b0);

    // All sources active: JumpReg wins.
    @(negedge clk);
    bus.JumpReg = 1'b1; bus.MistakeD = 1'b1; bus.BranchPrd = 1'b1; bus.Jump = 1'b1;
    bus.PCReg = 32'h100; bus.PCBranchD = 32'h104; bus.PCBranchF = 32'h108; bus.PCJump = 32'h10C;
    #1 chk_out("prio_jr", 32'h100, 3'd4, 1'b0, 1'b1);
    bus.JumpReg = 1'b0;
    #1 chk_out("prio_md", 32'h104, 3'd3, 1'b0, 1'b1);
    bus.MistakeD = 1'b0;
    #1 chk_out("prio_bp", 32'h108, 3'd2, 1'b0, 1'b0);

    // Fetch-stage jump, then low-bit forcing.
    @(negedge clk);
    bus.BranchPrd = 1'b0; bus.PCJump = 32'h40;
    #1 chk_out("jump", 32'h40, 3'd1, 1'b0, 1'b0);
    bus.PCJump = 32'h43;
    #1 chk_out("jump_lsb", 32'h40, 3'd1, 1'b0, 1'b0);

    // StallD gates decode redirects: no capture.
    @(negedge clk);
    idle();
    bus.StallD = 1'b1; bus.MistakeD = 1'b1; bus.PCBranchD = 32'h200;
    #1 chk_out("stalld", 32'h1004, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1 chk("stalld.RedirPend", {31'h0, bus.RedirPend}, 32'h0);

    // Miss capture of MistakeD.
    idle();
    bus.Ihit = 1'b0; bus.MistakeD = 1'b1; bus.PCBranchD = 32'h200;
    #1 chk("cap.FlushD", {31'h0, bus.FlushD}, 32'h1);
    chk("cap.StallF", {31'h0, bus.StallF}, 32'h1);
    @(negedge clk);
    #1 chk("cap.RedirPend", {31'h0, bus.RedirPend}, 32'h1);

    // Younger JumpReg plus fetch-stage redirects during the miss are ignored.
    bus.MistakeD = 1'b0; bus.JumpReg = 1'b1; bus.PCReg = 32'h300; bus.BranchPrd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("miss.FlushD", {31'h0, bus.FlushD}, 32'h0);
      chk("miss.StallF", {31'h0, bus.StallF}, 32'h1);
      @(negedge clk);
      chk("miss.RedirPend", {31'h0, bus.RedirPend}, 32'h1);
    end

    // Replay the older redirect when fetch advances.
    bus.Ihit = 1'b1; bus.Jump = 1'b1; bus.PCJump = 32'h700;
    #1 chk_out("replay", 32'h200, 3'd5, 1'b0, 1'b1);
    @(negedge clk);
    #1 chk("replay.RedirPend", {31'h0, bus.RedirPend}, 32'h0);
    chk_out("after_replay", 32'h300, 3'd4, 1'b0, 1'b1);

    // Simultaneous capture: JumpReg beats MistakeD; Dhit miss also freezes.
    @(negedge clk);
    idle();
    bus.Dhit = 1'b0; bus.JumpReg = 1'b1; bus.MistakeD = 1'b1;
    bus.PCReg = 32'h500; bus.PCBranchD = 32'h600;
    #1 chk("cap2.FlushD", {31'h0, bus.FlushD}, 32'h1);
    @(negedge clk);
    idle();
    #1 chk_out("replay2", 32'h500, 3'd5, 1'b0, 1'b1);

    // Capture again, then reset asynchronously while in MISS.
    @(negedge clk);
    idle();
    bus.Ihit = 1'b0; bus.JumpReg = 1'b1; bus.PCReg = 32'h800;
    @(negedge clk);
    #1 chk("pre_rst.RedirPend", {31'h0, bus.RedirPend}, 32'h1);
    #2 reset = 1'b0;
    #1 chk("rst_mid.RedirPend", {31'h0, bus.RedirPend}, 32'h0);
    chk_out("rst_mid", 32'h0, 3'd0, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    idle();
    bus.PCPlus4F = 32'h2000;
    #1 chk_out("post_rst", 32'h2000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk_out("post_rst_run", 32'h2000, 3'd0, 1'b0, 1'b0);

`ifdef FETCH_REDIR_PERF_EN
    // Counters: 5 miss cycles and 2 taken redirects, then miss counter wrap.
    @(negedge clk);
    reset = 1'b0;
    #1 chk("perf.rst_miss", {28'h0, MissCycCnt}, 32'h0);
    chk("perf.rst_redir", {28'h0, RedirCnt}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    bus.Ihit = 1'b0;
    repeat (5) @(negedge clk);
    bus.Ihit = 1'b1; bus.Jump = 1'b1; bus.PCJump = 32'h40;
    repeat (2) @(negedge clk);
    idle();
    #1 chk("perf.miss5", {28'h0, MissCycCnt}, 32'h5);
    chk("perf.redir2", {28'h0, RedirCnt}, 32'h2);
    bus.Ihit = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("perf.miss_max", {28'h0, MissCycCnt}, 32'hF);
    @(negedge clk);
    idle();
    #1 chk("perf.miss_wrap", {28'h0, MissCycCnt}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
